// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit bus responder.
// Accepts one load/store from the execute stage and checks it for illegal or
// misaligned access. It then runs a req/ack transaction on the data bus with
// a word address and byte mask, and returns extended load data with a
// one-cycle o_done pulse. The pipeline is stalled until o_done.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_vld,
    input  logic              i_mem_rw,
    input  logic [2:0]        i_type_access,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_st_data,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_bmask,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [31:0]       i_bus_rdata,
    output logic [31:0]       o_ld_data,
    output logic              o_done,
    output logic              o_err,
    output logic              o_stall
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_rw;
    logic [2:0]          r_type;
    logic [1:0]          r_off;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [3:0]          r_bmask;
    logic [31:0]         r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_ld_data;
    logic                r_done;
    logic                r_err;

    logic                w_legal;
    logic                w_aligned;
    logic [3:0]          w_bmask;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ext;
    logic                w_accept;
    logic                w_resp_ok;
    logic                w_resp_err;

    // Decode legality, alignment, byte mask and lane-replicated store data of the incoming request
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        w_bmask   = 4'b1111;
        w_wdata   = i_st_data;
        case (i_type_access)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~i_mem_rw;
            default:                w_legal = 1'b0;
        endcase
        case (i_type_access[1:0])
            2'b00: begin
                w_bmask = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                w_aligned = ~i_addr[0];
                w_bmask   = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata   = {2{i_st_data[15:0]}};
            end
            2'b10: begin
                w_aligned = (i_addr[1:0] == 2'b00);
            end
            default: begin
                w_aligned = 1'b1;
            end
        endcase
    end

    // Extract and extend the addressed lane of the returned bus word
    always_comb begin
        case (r_off)
            2'd0:    w_byte = i_bus_rdata[7:0];
            2'd1:    w_byte = i_bus_rdata[15:8];
            2'd2:    w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_type)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = i_bus_rdata;
        endcase
    end

    // Next-state logic and transaction events
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_resp_ok   = 1'b0;
        w_resp_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_vld && !r_done) begin
                    w_accept = 1'b1;
                    if (w_legal && w_aligned) begin
                        w_state_nxt = ST_BUS;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_resp_err  = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (i_bus_ack) begin
                    w_state_nxt = ST_RESP;
                    w_resp_ok   = 1'b1;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_RESP;
                    w_resp_err  = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, wait counter and registered response outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rw       <= 1'b0;
            r_type     <= '0;
            r_off      <= '0;
            r_bus_addr <= '0;
            r_bmask    <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ld_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rw       <= i_mem_rw;
                r_type     <= i_type_access;
                r_off      <= i_addr[1:0];
                r_bus_addr <= {i_addr[ADDR_W-1:2], 2'b00};
                r_bmask    <= w_bmask;
                r_wdata    <= w_wdata;
                r_cnt      <= '0;
            end else if (r_state == ST_BUS && !i_bus_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_done <= w_resp_ok | w_resp_err;
            r_err  <= w_resp_err;
            if (w_resp_ok) begin
                r_ld_data <= r_rw ? '0 : w_ext;
            end else if (w_resp_err) begin
                r_ld_data <= '0;
            end
        end
    end

    assign o_bus_req   = (r_state == ST_BUS);
    assign o_bus_we    = o_bus_req & r_rw;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_bmask = r_bmask;
    assign o_bus_wdata = r_wdata;
    assign o_ld_data   = r_ld_data;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_stall     = i_req_vld & ~r_done;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl.
// Each access pushes its expected load data and error flag. A monitor pops
// and compares them on every o_done pulse. The driver also checks bus fields,
// stall, latency and request length.
module tb_lsu_mem_ctrl;

    localparam int unsigned TO = 16;

    typedef struct {
        logic [31:0] ld;
        logic        err;
    } exp_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_req_vld;
    logic        i_mem_rw;
    logic [2:0]  i_type_access;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_bmask;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic [31:0] o_ld_data;
    logic        o_done;
    logic        o_err;
    logic        o_stall;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) u_dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_req_vld     (i_req_vld),
        .i_mem_rw      (i_mem_rw),
        .i_type_access (i_type_access),
        .i_addr        (i_addr),
        .i_st_data     (i_st_data),
        .o_bus_req     (o_bus_req),
        .o_bus_we      (o_bus_we),
        .o_bus_addr    (o_bus_addr),
        .o_bus_bmask   (o_bus_bmask),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ack     (i_bus_ack),
        .i_bus_rdata   (i_bus_rdata),
        .o_ld_data     (o_ld_data),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_stall       (o_stall)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: every completion must match the oldest expectation
    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && o_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ld_data", o_ld_data, e.ld);
                chk("err", {31'd0, o_err}, {31'd0, e.err});
            end
        end
    end

    // Drive one access and act as the bus slave; ack_dly < 0 means never ack
    task automatic run_acc(input logic rw, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] st, input logic [31:0] rdata, input int ack_dly,
                           input logic [31:0] exp_ld, input logic exp_err,
                           input logic [3:0] exp_bm, input logic [31:0] exp_wd,
                           input int exp_lat, input int exp_req);
        exp_t e;
        int   req_cnt;
        int   done_it;
        bit   done_seen;
        e.ld  = exp_ld;
        e.err = exp_err;
        sb_q.push_back(e);
        req_cnt   = 0;
        done_it   = 0;
        done_seen = 1'b0;
        @(negedge i_clk);
        i_req_vld     = 1'b1;
        i_mem_rw      = rw;
        i_type_access = typ;
        i_addr        = addr;
        i_st_data     = st;
        for (int it = 1; it <= 40 && !done_seen; it++) begin
            @(negedge i_clk);
            chk("stall", {31'd0, o_stall}, (it < exp_lat) ? 32'd1 : 32'd0);
            i_bus_ack = 1'b0;
            if (o_bus_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    chk("bus_addr", o_bus_addr, {addr[31:2], 2'b00});
                    chk("bus_bmask", {28'd0, o_bus_bmask}, {28'd0, exp_bm});
                    chk("bus_we", {31'd0, o_bus_we}, {31'd0, rw});
                    if (rw) chk("bus_wdata", o_bus_wdata, exp_wd);
                end
                if (ack_dly >= 0 && req_cnt == ack_dly + 1) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = rdata;
                end
            end
            if (o_done) begin
                done_seen = 1'b1;
                done_it   = it;
                i_req_vld = 1'b0;
            end
        end
        i_req_vld = 1'b0;
        i_bus_ack = 1'b0;
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        chk("latency", done_it, exp_lat);
        chk("req_cycles", req_cnt, exp_req);
    endtask

    initial begin
        i_reset       = 1'b0;
        i_req_vld     = 1'b0;
        i_mem_rw      = 1'b0;
        i_type_access = 3'b000;
        i_addr        = '0;
        i_st_data     = '0;
        i_bus_ack     = 1'b0;
        i_bus_rdata   = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_req", {31'd0, o_bus_req}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_ld", o_ld_data, 32'd0);
        chk("rst_baddr", o_bus_addr, 32'd0);
        chk("rst_bmask", {28'd0, o_bus_bmask}, 32'd0);
        i_reset = 1'b1;

        //      rw    typ     addr          st            rdata         dly ld            err   bm       wd            lat req
        run_acc(1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 4'b1000, 32'h0,        2, 1);
        run_acc(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 3, 32'h0000_BEEF, 1'b0, 4'b1100, 32'h0,        5, 4);
        run_acc(1'b1, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'h5555_5555, 0, 32'h0,        1'b0, 4'b0010, 32'hABAB_ABAB, 2, 1);
        run_acc(1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0);
        run_acc(1'b1, 3'b001, 32'h0000_0003, 32'hFFFF,     32'h0,         0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0);
        run_acc(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0);
        run_acc(1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0);
        run_acc(1'b0, 3'b111, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0);
        run_acc(1'b0, 3'b000, 32'h0000_1001, 32'h0,        32'h0000_7F00, 1, 32'h0000_007F, 1'b0, 4'b0010, 32'h0,        3, 2);
        run_acc(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_FFFF, 0, 32'hFFFF_8001, 1'b0, 4'b1100, 32'h0,        2, 1);
        run_acc(1'b0, 3'b100, 32'h0000_0003, 32'h0,        32'h80AA_AAAA, 0, 32'h0000_0080, 1'b0, 4'b1000, 32'h0,        2, 1);
        run_acc(1'b1, 3'b001, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        2, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 4, 3);
        run_acc(1'b0, 3'b010, 32'h0000_0004, 32'h0,        32'h1357_9BDF, 0, 32'h1357_9BDF, 1'b0, 4'b1111, 32'h0,        2, 1);

        // Store that is never acknowledged: request lasts TIMEOUT cycles
        run_acc(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,       -1, 32'h0,        1'b1, 4'b1111, 32'hCAFE_F00D, TO + 1, TO);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("late_ack_done", {31'd0, o_done}, 32'd0);
            chk("late_ack_req", {31'd0, o_bus_req}, 32'd0);
            i_bus_ack = (k < 2);
        end
        i_bus_ack = 1'b0;

        // Wait counter restarts: a long but in-budget wait still completes
        run_acc(1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h0BAD_F00D, 10, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0,      12, 11);

        // Asynchronous reset in the middle of a bus wait
        @(negedge i_clk);
        i_req_vld     = 1'b1;
        i_mem_rw      = 1'b0;
        i_type_access = 3'b010;
        i_addr        = 32'h0000_0040;
        repeat (3) @(negedge i_clk);
        chk("pre_rst_req", {31'd0, o_bus_req}, 32'd1);
        #2 i_reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, o_bus_req}, 32'd0);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk("mid_rst_bmask", {28'd0, o_bus_bmask}, 32'd0);
        i_req_vld = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        run_acc(1'b0, 3'b010, 32'h0000_0000, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        2, 1);

        repeat (3) @(negedge i_clk);
        chk("sb_left", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store responder for the RV32I core. It consumes the memory-access control decoded for the current instruction (read/write, access type = funct3) together with the ALU address and the rs2 data.
- It runs a request/acknowledge transaction on the data-memory bus, using a word-aligned address and byte mask.
- It returns sign- or zero-extended load data and stalls the pipeline until the access completes.
- It sits between the execute stage and the data memory / peripheral bus.

Parameters:
- ADDR_W, 32, byte-address width
- TIMEOUT, 16, maximum bus-wait cycles before an access is aborted with an error (≥2)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous active-low reset
- i_req_vld  in  1  load/store request from pipeline, held until o_done
- i_mem_rw  in  1  0 read (load), 1 write (store)
- i_type_access  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  ADDR_W  byte address from ALU
- i_st_data  in  32  store data (rs2), right-aligned
- o_bus_req  out  1  bus request
- o_bus_we  out  1  bus write enable
- o_bus_addr  out  ADDR_W  word address (addr[1:0]=00)
- o_bus_bmask  out  4  byte lanes
- o_bus_wdata  out  32  lane-aligned store data
- i_bus_ack  in  1  bus completion, one cycle
- i_bus_rdata  in  32  read word, valid with i_bus_ack
- o_ld_data  out  32  extended load result, valid with o_done
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  misaligned/illegal/timeout, valid with o_done
- o_stall  out  1  pipeline stall

Behaviour:
- Reset: state=IDLE; o_bus_req, o_bus_we, o_done, o_err = 0; o_bus_addr, o_bus_bmask, o_bus_wdata, o_ld_data = 0; timeout counter = 0. Reset mid-transaction aborts immediately. Bus must tolerate a dropped request.
- FSM states: IDLE, BUS, RESP.
- IDLE with i_req_vld=1 and o_done=0:
  - Capture mem_rw, type, addr[1:0], and the computed mask and wdata.
  - Illegal type (011, 110, 111, or 100/101 with store) → RESP with err=1.
  - Misaligned access (H/HU with addr[0]=1, W with addr[1:0]≠00) → RESP with err=1.
  - Otherwise → BUS, with o_bus_req=1 from the next cycle.
- Byte mask:
  - B/BU: 0001<<addr[1:0].
  - H/HU: 0011<<{addr[1],0}.
  - W: 1111.
- Store data replication:
  - B: {4{d[7:0]}}.
  - H: {2{d[15:0]}}.
  - W: d.
- BUS:
  - o_bus_req, we, addr, bmask and wdata are held stable until the ack.
  - i_bus_ack=1 → latch the extracted lane, drop o_bus_req the same edge, → RESP with err=0.
  - Counter increments each BUS cycle without ack. When it reaches TIMEOUT−1 with no ack → drop the request, → RESP with err=1. A late ack arriving in RESP or IDLE is ignored.
- Load extraction:
  - Select byte or half by the captured addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Stores return o_ld_data=0.
- RESP: o_done=1 for exactly one cycle, o_ld_data/o_err valid, → IDLE. o_done, o_err and o_ld_data are registered outputs.
- o_stall = i_req_vld & ~o_done (combinational). The pipeline advances on the o_done cycle.
- A new request is accepted no earlier than the cycle after o_done. There are no back-to-back same-cycle accepts.
- Minimum latency:
  - Accept at edge 0, o_bus_req high in cycle 1.
  - Ack in cycle 1 gives o_done in cycle 2: 2-cycle access.
  - Error paths: o_done the cycle after accept, with no bus activity.
- Counter resets to 0 on entry to BUS.

Test Plan:
- LB, addr=0x1003, bus rdata=0x80FF_1234, ack on first req cycle → bus_addr=0x1000, bmask=1000, o_done 2 cycles after accept, o_ld_data=0xFFFF_FF80, err=0.
- LHU, addr=0x2002, rdata=0xBEEF_0000, ack after 3 wait cycles → bmask=1100, ld_data=0x0000_BEEF, o_stall high until the o_done cycle.
- SB, addr=0x0001, st_data=0x1234_56AB → we=1, bmask=0010, wdata=0xABAB_ABAB, ld_data=0.
- LW, addr=0x0006 → no o_bus_req, o_done next cycle, err=1. Also SH at 0x0003 and type 011 both give err=1.
- SW with ack never asserted, TIMEOUT=16 → o_bus_req high 16 cycles then drops, o_done with err=1; a late ack afterwards causes no second o_done.
- Assert i_reset=0 mid-BUS → o_bus_req=0 and state IDLE immediately (asynchronously); after release, a new LW at 0x0 with rdata=0xDEAD_BEEF returns 0xDEAD_BEEF.
